param_updown_load_counter: RTL and testbench

//  Parametrised up/down counter with synchronous load, count enable and programmable

---
 rtl/param_updown_load_counter.sv | 74 +++++++
 tb/tb_param_updown_load_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/param_updown_load_counter.sv
// Up/down counter with clamped synchronous load, programmable terminal value,
// wrap / saturate / one-shot modes, cascade carry and sticky status flags.
module param_updown_load_counter #(
   parameter int WIDTH       = 4,
   parameter int MAX_COUNT   = 15,
   parameter int RESET_VALUE = 0,
   parameter int MODE        = 0
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             CE,
   input  logic             SLOAD,
   input  logic [WIDTH-1:0] D,
   input  logic             UP,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             CO,
   output logic             WRAP,
   output logic             OVF,
   output logic             DONE
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VALUE);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] q_n;
   logic             wrap_n;
   logic             ovf_n;
   logic             done_n;

   assign TC = UP ? (Q == MAXV) : (Q == '0);
   assign CO = TC & CE & ~SLOAD & ~DONE;

   // terminal check comes before the step, so Q never leaves 0..MAX_COUNT
   always_comb begin
      q_n    = Q;
      wrap_n = 1'b0;
      ovf_n  = OVF;
      done_n = DONE;
      if (SLOAD) begin
         q_n    = (D > MAXV) ? MAXV : D;
         ovf_n  = 1'b0;
         done_n = 1'b0;
      end else if (CE && !DONE) begin
         if (!TC) begin
            q_n = UP ? (Q + ONE) : (Q - ONE);
         end else begin
            ovf_n = 1'b1;
            if (MODE == 0) begin
               q_n    = UP ? '0 : MAXV;
               wrap_n = 1'b1;
            end else if (MODE == 2) begin
               done_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         Q    <= RSTV;
         WRAP <= 1'b0;
         OVF  <= 1'b0;
         DONE <= 1'b0;
      end else begin
         Q    <= q_n;
         WRAP <= wrap_n;
         OVF  <= ovf_n;
         DONE <= done_n;
      end
   end

endmodule

// File: tb/tb_param_updown_load_counter.sv
// Directed bench for param_updown_load_counter: per-mode instances plus a
// two-stage cascade, checked through an expected-value queue.
module tb_param_updown_load_counter;

   logic       clk = 1'b0;
   logic       clr, ce, sl, up;
   logic [3:0] d;
   logic       cclr, cce;

   logic [3:0] q0, q1, q2, ql, qh;
   logic       tc0, co0, wr0, ov0, dn0;
   logic       tc1, co1, wr1, ov1, dn1;
   logic       tc2, co2, wr2, ov2, dn2;
   logic       tcl, col, wrl, ovl, dnl;
   logic       tch, coh, wrh, ovh, dnh;

   always #5 clk = ~clk;

   param_updown_load_counter #(.WIDTH(4), .MAX_COUNT(9),
      .RESET_VALUE(0), .MODE(0)) m0 (
      .C(clk), .CLR(clr), .CE(ce), .SLOAD(sl), .D(d), .UP(up),
      .Q(q0), .TC(tc0), .CO(co0), .WRAP(wr0), .OVF(ov0), .DONE(dn0));

   param_updown_load_counter #(.WIDTH(4), .MAX_COUNT(9),
      .RESET_VALUE(0), .MODE(1)) m1 (
      .C(clk), .CLR(clr), .CE(ce), .SLOAD(sl), .D(d), .UP(up),
      .Q(q1), .TC(tc1), .CO(co1), .WRAP(wr1), .OVF(ov1), .DONE(dn1));

   param_updown_load_counter #(.WIDTH(4), .MAX_COUNT(9),
      .RESET_VALUE(0), .MODE(2)) m2 (
      .C(clk), .CLR(clr), .CE(ce), .SLOAD(sl), .D(d), .UP(up),
      .Q(q2), .TC(tc2), .CO(co2), .WRAP(wr2), .OVF(ov2), .DONE(dn2));

   param_updown_load_counter #(.WIDTH(4), .MAX_COUNT(9),
      .RESET_VALUE(0), .MODE(0)) lo (
      .C(clk), .CLR(cclr), .CE(cce), .SLOAD(1'b0), .D(4'd0), .UP(1'b1),
      .Q(ql), .TC(tcl), .CO(col), .WRAP(wrl), .OVF(ovl), .DONE(dnl));

   param_updown_load_counter #(.WIDTH(4), .MAX_COUNT(9),
      .RESET_VALUE(0), .MODE(0)) hi (
      .C(clk), .CLR(cclr), .CE(col), .SLOAD(1'b0), .D(4'd0), .UP(1'b1),
      .Q(qh), .TC(tch), .CO(coh), .WRAP(wrh), .OVF(ovh), .DONE(dnh));

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   lm, hm;

   task automatic push(input string t, input logic [31:0] v);
      exp_t e;
      e.tag = t;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $error("FAIL sb_empty obs=%0d exp=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s obs=%0d exp=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1; ce = 1'b0; sl = 1'b0; up = 1'b1; d = 4'd0;
      cclr = 1'b1; cce = 1'b0;
      #2;
      push("rst_q", 0); push("rst_wrap", 0);
      push("rst_ovf", 0); push("rst_done", 0);
      chk(q0); chk(wr0); chk(ov0); chk(dn2);
      #10;
      clr = 1'b0; cclr = 1'b0;

      // mode 0 up, wrap at 9
      ce = 1'b1; up = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         push("m0_up_q", i % 10);
         push("m0_up_wrap", i == 10);
         push("m0_up_ovf", i >= 10);
         push("m0_up_tc", i == 9);
         push("m0_up_co", i == 9);
         tick();
         chk(q0); chk(wr0); chk(ov0); chk(tc0); chk(co0);
      end
      push("m0_done", 0);
      chk(dn0);

      // mode 0 down
      sl = 1'b1; d = 4'd2;
      push("m0_ld_q", 2); push("m0_ld_ovf", 0);
      tick();
      chk(q0); chk(ov0);
      sl = 1'b0; up = 1'b0;
      push("m0_dn_q", 1); push("m0_dn_wrap", 0);
      tick(); chk(q0); chk(wr0);
      push("m0_dn_q", 0); push("m0_dn_tc", 1);
      tick(); chk(q0); chk(tc0);
      push("m0_dn_q", 9); push("m0_dn_wrap", 1); push("m0_dn_ovf", 1);
      tick(); chk(q0); chk(wr0); chk(ov0);
      push("m0_dn_q", 8); push("m0_dn_wrap", 0);
      tick(); chk(q0); chk(wr0);
      sl = 1'b1; d = 4'd12;
      push("m0_clamp_q", 9); push("m0_clamp_ovf", 0);
      tick(); chk(q0); chk(ov0);

      // mode 1 saturate
      sl = 1'b1; d = 4'd7; up = 1'b1;
      push("m1_ld_q", 7);
      tick(); chk(q1);
      sl = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         push("m1_q", (i == 1) ? 8 : 9);
         push("m1_wrap", 0);
         push("m1_ovf", i >= 3);
         tick();
         chk(q1); chk(wr1); chk(ov1);
      end
      up = 1'b0;
      push("m1_down_q", 8);
      tick(); chk(q1);

      // mode 2 one-shot
      sl = 1'b1; d = 4'd8; up = 1'b1;
      push("m2_ld_q", 8); push("m2_ld_done", 0);
      tick(); chk(q2); chk(dn2);
      sl = 1'b0;
      push("m2_q", 9); push("m2_done", 0);
      tick(); chk(q2); chk(dn2);
      push("m2_q", 9); push("m2_done", 1); push("m2_ovf", 1);
      tick(); chk(q2); chk(dn2); chk(ov2);
      for (int i = 0; i < 4; i++) begin
         push("m2_frz_q", 9); push("m2_frz_done", 1); push("m2_frz_co", 0);
         tick();
         chk(q2); chk(dn2); chk(co2);
      end
      up = 1'b0;
      push("m2_frz_dn_q", 9);
      tick(); chk(q2);
      sl = 1'b1; d = 4'd3;
      push("m2_rld_q", 3); push("m2_rld_done", 0); push("m2_rld_ovf", 0);
      tick(); chk(q2); chk(dn2); chk(ov2);

      // load beats count, then async clear
      ce = 1'b1; sl = 1'b1; d = 4'd5; up = 1'b1;
      push("pri_q", 5);
      tick(); chk(q0);
      sl = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      push("aclr_q", 0); push("aclr_ovf", 0);
      chk(q0); chk(ov0);
      for (int i = 0; i < 3; i++) begin
         push("clr_hold_q", 0);
         tick(); chk(q0);
      end
      clr = 1'b0;
      push("clr_rel_q", 1);
      tick(); chk(q0);

      // cascade
      ce = 1'b0;
      lm = 0; hm = 0;
      cce = 1'b1;
      for (int i = 0; i < 25; i++) begin
         push("casc_co", lm == 9);
         chk(col);
         if (lm == 9) hm = (hm + 1) % 10;
         lm = (lm + 1) % 10;
         push("casc_lo", lm); push("casc_hi", hm);
         tick();
         chk(ql); chk(qh);
      end
      push("casc_lo_end", 5); push("casc_hi_end", 2);
      chk(ql); chk(qh);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
